// File: rtl/sa_autosa_pdp_rdma_egress_if.sv
// rtl/sa_autosa_pdp_rdma_egress_if.sv - PDP RDMA egress element-in / payload-out handshake bundle
// master = memory return + datapath side, slave = egress block.
interface sa_autosa_pdp_rdma_egress_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0]  dma_rd_rsp_pd;
   logic               dma_rd_rsp_valid;
   logic               dma_rd_rsp_ready;
   logic [DATA_W+13:0] pdp_rdma2dp_pd;
   logic               pdp_rdma2dp_valid;
   logic               pdp_rdma2dp_ready;
   logic               rdma_done;

   modport master (
      output dma_rd_rsp_pd,
      output dma_rd_rsp_valid,
      input  dma_rd_rsp_ready,
      input  pdp_rdma2dp_pd,
      input  pdp_rdma2dp_valid,
      output pdp_rdma2dp_ready,
      input  rdma_done
   );

   modport slave (
      input  dma_rd_rsp_pd,
      input  dma_rd_rsp_valid,
      output dma_rd_rsp_ready,
      output pdp_rdma2dp_pd,
      output pdp_rdma2dp_valid,
      input  pdp_rdma2dp_ready,
      output rdma_done
   );
endinterface

// File: rtl/sa_autosa_pdp_rdma_egress.sv
// rtl/sa_autosa_pdp_rdma_egress.sv - PDP RDMA egress: cube walker, position flags, output FIFO
// Elements are tagged split->channel->line->element order and queued towards the 1D pooling stage.
module sa_autosa_pdp_rdma_egress #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        autosa_core_clk,
   input  logic        autosa_core_rstn,
   input  logic        reg2dp_op_en,
   input  logic [12:0] reg2dp_cube_in_width,
   input  logic [12:0] reg2dp_cube_in_height,
   input  logic [12:0] reg2dp_cube_in_channel,
   input  logic [7:0]  pooling_splitw_num_cfg,
   input  logic [9:0]  pooling_fwidth_cfg,
   input  logic [9:0]  pooling_mwidth_cfg,
   input  logic [9:0]  pooling_lwidth_cfg,
   sa_autosa_pdp_rdma_egress_if.slave bus
);
   localparam int PW = DATA_W + 14;
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]    r_state;
   logic          r_op_en_d;
   logic [12:0]   r_cfg_width;
   logic [12:0]   r_cfg_height;
   logic [12:0]   r_cfg_channel;
   logic [7:0]    r_cfg_splitw;
   logic [9:0]    r_cfg_fw;
   logic [9:0]    r_cfg_mw;
   logic [9:0]    r_cfg_lw;
   // w spans the full 13-bit cube width so the unsplit case never truncates
   logic [12:0]   r_w;
   logic [12:0]   r_h;
   logic [12:0]   r_c;
   logic [7:0]    r_s;
   logic [PW-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   logic [12:0]   w_wsplit;
   logic          w_start;
   logic          w_cube_start;
   logic          w_line_end;
   logic          w_surf_end;
   logic          w_split_end;
   logic          w_cube_end;
   logic          w_full;
   logic          w_in_ready;
   logic          w_push;
   logic          w_pop;
   logic          w_done;
   logic [PW-1:0] w_entry;
   logic [PW-1:0] w_head;

   always_comb begin
      w_wsplit = {3'b000, r_cfg_mw};
      if (r_cfg_splitw == 8'd0)
         w_wsplit = r_cfg_width;
      else if (r_s == 8'd0)
         w_wsplit = {3'b000, r_cfg_fw};
      else if (r_s == r_cfg_splitw)
         w_wsplit = {3'b000, r_cfg_lw};
   end

   assign w_start      = reg2dp_op_en & ~r_op_en_d & (r_state == ST_IDLE);
   assign w_cube_start = (r_w == 13'd0) & (r_h == 13'd0) & (r_c == 13'd0) & (r_s == 8'd0);
   assign w_line_end   = (r_w == w_wsplit);
   assign w_surf_end   = w_line_end & (r_h == r_cfg_height);
   assign w_split_end  = w_surf_end & (r_c == r_cfg_channel);
   assign w_cube_end   = w_split_end & (r_s == r_cfg_splitw);

   assign w_entry = {1'b0, r_s, w_cube_end, w_split_end, w_surf_end, w_line_end,
                     w_cube_start, bus.dma_rd_rsp_pd};

   // Ready comes from registered occupancy only, so a full FIFO never sees push and pop together
   assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_in_ready = (r_state == ST_RUN) & ~w_full;
   assign w_push     = bus.dma_rd_rsp_valid & w_in_ready;
   assign w_head     = r_mem[r_rptr];
   assign w_pop      = (r_count != '0) & bus.pdp_rdma2dp_ready;
   assign w_done     = w_pop & w_head[DATA_W+4] & (r_state == ST_DRAIN);

   assign bus.dma_rd_rsp_ready  = w_in_ready;
   assign bus.pdp_rdma2dp_valid = (r_count != '0);
   assign bus.pdp_rdma2dp_pd    = w_head;
   assign bus.rdma_done         = w_done;

   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         r_state       <= ST_IDLE;
         r_op_en_d     <= 1'b0;
         r_cfg_width   <= '0;
         r_cfg_height  <= '0;
         r_cfg_channel <= '0;
         r_cfg_splitw  <= '0;
         r_cfg_fw      <= '0;
         r_cfg_mw      <= '0;
         r_cfg_lw      <= '0;
         r_w           <= '0;
         r_h           <= '0;
         r_c           <= '0;
         r_s           <= '0;
      end else begin
         r_op_en_d <= reg2dp_op_en;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_cfg_width   <= reg2dp_cube_in_width;
                  r_cfg_height  <= reg2dp_cube_in_height;
                  r_cfg_channel <= reg2dp_cube_in_channel;
                  r_cfg_splitw  <= pooling_splitw_num_cfg;
                  r_cfg_fw      <= pooling_fwidth_cfg;
                  r_cfg_mw      <= pooling_mwidth_cfg;
                  r_cfg_lw      <= pooling_lwidth_cfg;
                  r_w           <= '0;
                  r_h           <= '0;
                  r_c           <= '0;
                  r_s           <= '0;
                  r_state       <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_push) begin
                  if (w_cube_end)
                     r_state <= ST_DRAIN;
                  if (!w_line_end) begin
                     r_w <= r_w + 13'd1;
                  end else begin
                     r_w <= '0;
                     if (!w_surf_end) begin
                        r_h <= r_h + 13'd1;
                     end else begin
                        r_h <= '0;
                        if (!w_split_end) begin
                           r_c <= r_c + 13'd1;
                        end else begin
                           r_c <= '0;
                           r_s <= w_cube_end ? 8'd0 : r_s + 8'd1;
                        end
                     end
                  end
               end
            end
            ST_DRAIN: begin
               if (w_done)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_mem[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= w_entry;
            r_wptr        <= r_wptr + AW'(1);
         end
         if (w_pop)
            r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: tb/tb_sa_autosa_pdp_rdma_egress.sv
// tb/tb_sa_autosa_pdp_rdma_egress.sv - self-checking bench for the PDP RDMA egress block
// Expected payloads come from nested-loop cube enumeration; a negedge monitor scores every output.
module tb_sa_autosa_pdp_rdma_egress;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        op_en = 1'b0;
   logic [12:0] cfg_w = '0;
   logic [12:0] cfg_h = '0;
   logic [12:0] cfg_c = '0;
   logic [7:0]  cfg_s = '0;
   logic [9:0]  cfg_f = '0;
   logic [9:0]  cfg_m = '0;
   logic [9:0]  cfg_l = '0;

   sa_autosa_pdp_rdma_egress_if #(.DATA_W(8)) bus();

   sa_autosa_pdp_rdma_egress #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
      .autosa_core_clk        (clk),
      .autosa_core_rstn       (rstn),
      .reg2dp_op_en           (op_en),
      .reg2dp_cube_in_width   (cfg_w),
      .reg2dp_cube_in_height  (cfg_h),
      .reg2dp_cube_in_channel (cfg_c),
      .pooling_splitw_num_cfg (cfg_s),
      .pooling_fwidth_cfg     (cfg_f),
      .pooling_mwidth_cfg     (cfg_m),
      .pooling_lwidth_cfg     (cfg_l),
      .bus                    (bus)
   );

   always #5 clk = ~clk;

   int          n_pass = 0;
   int          n_chk = 0;
   logic [21:0] exp_q[$];
   logic [7:0]  src_q[$];
   int          sent = 0;
   int          done_cnt = 0;
   int          first_hs = -1;
   int          last_hs = -1;
   int          cyc = 0;
   logic        mon_en = 1'b0;
   logic        prev_stall = 1'b0;
   logic [21:0] prev_pd = '0;
   logic        exp_done;
   logic [21:0] e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Enumerate the cube as the pooling stage sees it: split, channel, line, element
   function automatic void build(input int W, input int H, input int C, input int S,
                                 input int F, input int M, input int L, input logic [7:0] base);
      int k;
      int ws;
      logic [7:0] d;
      logic le, se, pe, ce;
      k = 0;
      exp_q.delete();
      src_q.delete();
      for (int s = 0; s <= S; s++) begin
         ws = (S == 0) ? W : (s == 0) ? F : (s == S) ? L : M;
         for (int c = 0; c <= C; c++)
            for (int h = 0; h <= H; h++)
               for (int w = 0; w <= ws; w++) begin
                  d  = base + 8'(k);
                  le = (w == ws);
                  se = le && (h == H);
                  pe = se && (c == C);
                  ce = pe && (s == S);
                  src_q.push_back(d);
                  exp_q.push_back({1'b0, 8'(s), ce, pe, se, le, (k == 0), d});
                  k++;
               end
      end
   endfunction

   task automatic start(input int W, input int H, input int C, input int S,
                        input int F, input int M, input int L, input logic [7:0] base);
      build(W, H, C, S, F, M, L, base);
      cfg_w = 13'(W); cfg_h = 13'(H); cfg_c = 13'(C); cfg_s = 8'(S);
      cfg_f = 10'(F); cfg_m = 10'(M); cfg_l = 10'(L);
      first_hs = -1;
      @(posedge clk); #1 op_en = 1'b1;
      @(posedge clk); #1 op_en = 1'b0;
   endtask

   task automatic send(input int lim, input bit bubble);
      int t;
      bit tog;
      t = 0;
      tog = 1'b0;
      sent = 0;
      while (sent < lim && t < 2000) begin
         @(posedge clk); #1;
         tog = ~tog;
         bus.dma_rd_rsp_valid = bubble ? tog : 1'b1;
         bus.dma_rd_rsp_pd    = src_q[sent];
         @(negedge clk);
         if (bus.dma_rd_rsp_valid && bus.dma_rd_rsp_ready) sent++;
         t++;
      end
      @(posedge clk); #1 bus.dma_rd_rsp_valid = 1'b0;
      chk("send_count", sent, lim);
   endtask

   task automatic drain(input int done_total, input string nm);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk({nm, "_drained"}, exp_q.size(), 0);
      chk({nm, "_done_cnt"}, done_cnt, done_total);
   endtask

   always @(negedge clk) begin
      if (!mon_en) begin
         prev_stall = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (prev_stall) begin
            chk("hold_valid", bus.pdp_rdma2dp_valid, 1);
            chk("hold_pd", bus.pdp_rdma2dp_pd, prev_pd);
         end
         if (bus.pdp_rdma2dp_valid && bus.pdp_rdma2dp_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("payload", bus.pdp_rdma2dp_pd, e);
               exp_done = e[12];
               if (first_hs < 0) first_hs = cyc;
               last_hs = cyc;
            end
         end
         chk("rdma_done", bus.rdma_done, exp_done);
         if (bus.rdma_done) done_cnt++;
         prev_stall = bus.pdp_rdma2dp_valid && !bus.pdp_rdma2dp_ready;
         prev_pd    = bus.pdp_rdma2dp_pd;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bus.dma_rd_rsp_valid  = 1'b0;
      bus.dma_rd_rsp_pd     = '0;
      bus.pdp_rdma2dp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", bus.dma_rd_rsp_ready, 0);
      chk("rst_out_valid", bus.pdp_rdma2dp_valid, 0);
      chk("rst_out_pd", bus.pdp_rdma2dp_pd, 0);
      chk("rst_done", bus.rdma_done, 0);
      rstn = 1'b1;
      mon_en = 1'b1;

      // Single split, 4 wide x 2 high
      start(3, 1, 0, 0, 0, 0, 0, 8'hA0);
      chk("t1_size", exp_q.size(), 8);
      chk("t1_e0", exp_q[0], 22'h0001A0);
      chk("t1_e3", exp_q[3], 22'h0002A3);
      chk("t1_e7", exp_q[7], 22'h001EA7);
      send(8, 1'b0);
      drain(1, "t1");
      chk("t1_rate", last_hs - first_hs, 7);

      // Three width splits of 2, 3 and 1 elements
      start(0, 0, 0, 2, 1, 2, 0, 8'h10);
      chk("t2_size", exp_q.size(), 6);
      chk("t2_e0", exp_q[0], 22'h000110);
      chk("t2_e1", exp_q[1], 22'h000E11);
      chk("t2_e2", exp_q[2], 22'h002012);
      chk("t2_e4", exp_q[4], 22'h002E14);
      chk("t2_e5", exp_q[5], 22'h005E15);
      send(6, 1'b0);
      drain(2, "t2");

      // Downstream stalled for 10 cycles with input continuously offered
      bus.pdp_rdma2dp_ready = 1'b0;
      start(3, 1, 0, 0, 0, 0, 0, 8'h30);
      fork
         send(8, 1'b0);
         begin
            repeat (10) @(posedge clk);
            #2;
            chk("bp_accepted", sent, 4);
            chk("bp_in_ready_low", bus.dma_rd_rsp_ready, 0);
            chk("bp_out_valid", bus.pdp_rdma2dp_valid, 1);
            bus.pdp_rdma2dp_ready = 1'b1;
         end
      join
      drain(3, "t3");

      // Same cube as the first run with gaps on the input
      start(3, 1, 0, 0, 0, 0, 0, 8'hA0);
      send(8, 1'b1);
      drain(4, "t4");

      // Start re-pulsed and height changed mid-cube
      start(3, 1, 0, 0, 0, 0, 0, 8'h60);
      fork
         send(8, 1'b0);
         begin
            repeat (3) @(posedge clk);
            #2 op_en = 1'b1;
            cfg_h = 13'd5;
            repeat (2) @(posedge clk);
            #2 op_en = 1'b0;
         end
      join
      drain(5, "t5");
      chk("t5_idle", bus.dma_rd_rsp_ready, 0);

      // Reset in the middle of a 64-element cube, then a one-element cube
      start(7, 7, 0, 0, 0, 0, 0, 8'h00);
      chk("t6_size", exp_q.size(), 64);
      send(20, 1'b0);
      mon_en = 1'b0;
      #3 rstn = 1'b0;
      #1;
      chk("t6_rst_in_ready", bus.dma_rd_rsp_ready, 0);
      chk("t6_rst_valid", bus.pdp_rdma2dp_valid, 0);
      chk("t6_rst_pd", bus.pdp_rdma2dp_pd, 0);
      chk("t6_rst_done", bus.rdma_done, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      mon_en = 1'b1;
      start(0, 0, 0, 0, 0, 0, 0, 8'h5A);
      chk("t6_e0", exp_q[0], 22'h001F5A);
      send(1, 1'b0);
      drain(6, "t6");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
